// File: rtl/axi3_slave_lbus_bridge.sv
// AXI3 slave that replays each burst beat as a single lbus request, one transaction at a time.
// Define AXI_SLV_WRAP_EN to honour WRAP bursts; otherwise WRAP advances like INCR.
module axi3_slave_lbus_bridge #(
  parameter int AddrW    = 8,
  parameter int DataW    = 32,
  parameter int IdW      = 2,
  parameter int AxiIdW   = 4,
  parameter int StrbW    = DataW / 8,
  parameter int AxiBlenW = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [AxiIdW-1:0]   axi_awid,
  input  logic [AddrW-1:0]    axi_awaddr,
  input  logic [AxiBlenW-1:0] axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awreadyo,
  input  logic [DataW-1:0]    axi_wdata,
  input  logic [StrbW-1:0]    axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wreadyo,
  output logic [AxiIdW-1:0]   axi_bido,
  output logic [1:0]          axi_brespo,
  output logic                axi_bvalido,
  input  logic                axi_bready,
  input  logic [AxiIdW-1:0]   axi_arid,
  input  logic [AddrW-1:0]    axi_araddr,
  input  logic [AxiBlenW-1:0] axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arreadyo,
  output logic [AxiIdW-1:0]   axi_rido,
  output logic [DataW-1:0]    axi_rdatao,
  output logic [1:0]          axi_rrespo,
  output logic                axi_rlasto,
  output logic                axi_rvalido,
  input  logic                axi_rready,
  output logic                lbus_reqo,
  output logic [IdW-1:0]      lbus_ido,
  output logic [StrbW-1:0]    lbus_strbo,
  output logic [AddrW-1:0]    lbus_addro,
  output logic [DataW-1:0]    lbus_wdatao,
  input  logic                lbus_ready,
  input  logic [DataW-1:0]    lbus_rdata,
  input  logic                lbus_busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_t;

  localparam logic [AddrW-1:0] One = AddrW'(1);

  state_t               state;
  logic                 rr;
  logic [AxiIdW-1:0]    id_q;
  logic [AddrW-1:0]     addr_q;
  logic [AxiBlenW-1:0]  len_q;
  logic [AxiBlenW-1:0]  beat_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [DataW-1:0]     rdata_q;
  logic [DataW-1:0]     wdata_q;
  logic [StrbW-1:0]     strb_q;

  logic                 grant_rd;
  logic                 grant_wr;
  logic                 last_beat;
  logic                 wr_beat_done;
  logic [AddrW-1:0]     size_bytes;
  logic [AddrW-1:0]     incr_addr;
  logic [AddrW-1:0]     next_addr;
  logic                 unused_inputs;

  assign unused_inputs = axi_wlast;

  // rr set means the write channel wins the next simultaneous request.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE) begin
      if (axi_arvalid && axi_awvalid) begin
        grant_rd = !rr;
        grant_wr = rr;
      end else begin
        grant_rd = axi_arvalid;
        grant_wr = axi_awvalid;
      end
    end
  end

  assign last_beat = (beat_q == len_q);

  // A zero-strobe beat completes without touching the lbus.
  assign wr_beat_done = ((state == WR_DATA) && axi_wvalid && (axi_wstrb == '0)) ||
                        ((state == WR_REQ) && !lbus_busy && lbus_ready) ||
                        ((state == WR_WAIT) && lbus_ready);

`ifdef AXI_SLV_WRAP_EN
  logic [AddrW-1:0] wrap_mask;
  assign wrap_mask = ((AddrW'(len_q) + One) << size_q) - One;
`endif

  always_comb begin
    size_bytes = One << size_q;
    incr_addr  = (addr_q & ~(size_bytes - One)) + size_bytes;
    next_addr  = incr_addr;
    case (burst_q)
      2'b00: next_addr = addr_q;
`ifdef AXI_SLV_WRAP_EN
      2'b10: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default: next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr      <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            rr     <= !rr;
            beat_q <= '0;
          end
          if (grant_rd) begin
            id_q    <= axi_arid;
            addr_q  <= axi_araddr;
            len_q   <= axi_arlen;
            size_q  <= axi_arsize;
            burst_q <= axi_arburst;
            strb_q  <= '0;
            state   <= RD_REQ;
          end else if (grant_wr) begin
            id_q    <= axi_awid;
            addr_q  <= axi_awaddr;
            len_q   <= axi_awlen;
            size_q  <= axi_awsize;
            burst_q <= axi_awburst;
            state   <= WR_DATA;
          end
        end
        RD_REQ: begin
          if (!lbus_busy) begin
            if (lbus_ready) begin
              rdata_q <= lbus_rdata;
              state   <= RD_DATA;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lbus_ready) begin
            rdata_q <= lbus_rdata;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= next_addr;
              state  <= RD_REQ;
            end
          end
        end
        WR_DATA, WR_REQ, WR_WAIT: begin
          if (state == WR_DATA && axi_wvalid) begin
            wdata_q <= axi_wdata;
            strb_q  <= axi_wstrb;
          end
          if (wr_beat_done) begin
            if (last_beat) begin
              state <= WR_RESP;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= next_addr;
              state  <= WR_DATA;
            end
          end else if (state == WR_DATA && axi_wvalid) begin
            state <= WR_REQ;
          end else if (state == WR_REQ && !lbus_busy) begin
            state <= WR_WAIT;
          end
        end
        WR_RESP: begin
          if (axi_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake rule: a transfer happens on any clock edge where valid and ready are both high.
  assign axi_arreadyo = grant_rd;
  assign axi_awreadyo = grant_wr;
  assign axi_wreadyo  = (state == WR_DATA);
  assign axi_bvalido  = (state == WR_RESP);
  assign axi_bido     = id_q;
  assign axi_brespo   = 2'b00;
  assign axi_rvalido  = (state == RD_DATA);
  assign axi_rlasto   = (state == RD_DATA) && last_beat;
  assign axi_rdatao   = rdata_q;
  assign axi_rido     = id_q;
  assign axi_rrespo   = 2'b00;
  assign lbus_reqo    = ((state == RD_REQ) || (state == WR_REQ)) && !lbus_busy;
  assign lbus_ido     = '0;
  assign lbus_strbo   = strb_q;
  assign lbus_addro   = addr_q;
  assign lbus_wdatao  = wdata_q;
  assign dbg_state    = state;

endmodule
